// File: rtl/gpu_pkg.sv
// Shared GPU definitions: opcode encoding, instruction field layout and the
// warp sequencer state encoding.
package gpu_pkg;

    // Broadcast opcode carried in bits [31:29] of every instruction word
    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_ADD  = 3'b011,
        OP_FADD = 3'b100,
        OP_FSUB = 3'b101,
        OP_INIT = 3'b110,
        OP_END  = 3'b111
    } opcode_e;

    // Field positions inside the 32-bit instruction word; [7:0] carries nothing
    localparam int TYPE_LSB  = 29;
    localparam int R1_LSB    = 24;
    localparam int R2_LSB    = 19;
    localparam int DST_LSB   = 14;
    localparam int SHAMT_LSB = 8;
    localparam int REG_W     = 5;
    localparam int SHAMT_W   = 6;

    typedef struct packed {
        opcode_e              op;
        logic [REG_W-1:0]     regnum_1;
        logic [REG_W-1:0]     regnum_2;
        logic [REG_W-1:0]     dest_reg;
        logic [SHAMT_W-1:0]   shammt;
    } instr_fields_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

endpackage

// File: rtl/warp_sequencer_if.sv
// Instruction-memory bus plus the lockstep broadcast to the thread units.
// master = sequencer side, slave = memory/thread-array side.
interface warp_sequencer_if #(
    parameter int NUM_THREADS = 8,
    parameter int PCW         = 6
);
    logic [PCW-1:0]         imem_addr;
    logic [31:0]            imem_rdata;
    logic [2:0]             type_instruction;
    logic [4:0]             regnum_1;
    logic [4:0]             regnum_2;
    logic [4:0]             dest_reg;
    logic [5:0]             shammt;
    logic [NUM_THREADS-1:0] thread_active;
    logic [NUM_THREADS-1:0] thread_complete;

    modport master (
        output imem_addr, type_instruction, regnum_1, regnum_2, dest_reg, shammt, thread_active,
        input  imem_rdata, thread_complete
    );

    modport slave (
        input  imem_addr, type_instruction, regnum_1, regnum_2, dest_reg, shammt, thread_active,
        output imem_rdata, thread_complete
    );
endinterface

// File: rtl/warp_sequencer_instr_decode.sv
// Combinational split of an instruction word into its broadcast fields.
module instr_decode
    import gpu_pkg::*;
(
    input  logic [31:0]   instr_word,
    output instr_fields_t fields
);
    // Low byte is reserved and deliberately dropped
    logic unused_low;

    assign fields.op       = opcode_e'(instr_word[TYPE_LSB +: 3]);
    assign fields.regnum_1 = instr_word[R1_LSB +: REG_W];
    assign fields.regnum_2 = instr_word[R2_LSB +: REG_W];
    assign fields.dest_reg = instr_word[DST_LSB +: REG_W];
    assign fields.shammt   = instr_word[SHAMT_LSB +: SHAMT_W];
    assign unused_low      = ^instr_word[SHAMT_LSB-1:0];
endmodule

// File: rtl/warp_sequencer.sv
// Warp sequencer: fetches one instruction every two cycles and broadcasts it
// to NUM_THREADS lockstep units, then waits for every active unit to finish.
// Optional feature macro: WARP_SEQ_TIMEOUT_EN (issue-limit watchdog).
module warp_sequencer
    import gpu_pkg::*;
#(
    parameter int  NUM_THREADS = 8,
    parameter int  IMEM_DEPTH  = 64,
    parameter int  MAX_INSTR   = 255,
    localparam int PCW         = $clog2(IMEM_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [PCW-1:0]         base_pc,
    input  logic [NUM_THREADS-1:0] active_mask,
    warp_sequencer_if.master       seq_bus,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err
);
    seq_state_e             state_reg, state_next;
    logic [PCW-1:0]         pc_reg, pc_next;
    logic [NUM_THREADS-1:0] mask_reg, mask_next;
    instr_fields_t          fields;
    logic                   issue_valid;
    logic                   force_end;

    instr_decode u_decode (
        .instr_word (seq_bus.imem_rdata),
        .fields     (fields)
    );

`ifdef WARP_SEQ_TIMEOUT_EN
    localparam int CNTW = $clog2(MAX_INSTR + 1);

    logic [CNTW-1:0] issue_cnt_reg, issue_cnt_next;
    logic            timeout_reg, timeout_next;

    // Watchdog state: issue count for the current program and sticky error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            issue_cnt_reg <= issue_cnt_next;
            timeout_reg   <= timeout_next;
        end
    end

    // Count issues; the MAX_INSTR-th non-END issue is turned into END
    always_comb begin
        issue_cnt_next = issue_cnt_reg;
        timeout_next   = timeout_reg;
        force_end      = (state_reg == ST_ISSUE) && (fields.op != OP_END) &&
                         (issue_cnt_reg == CNTW'(MAX_INSTR - 1));
        if (state_reg == ST_IDLE && start) begin
            issue_cnt_next = '0;
            timeout_next   = 1'b0;
        end else if (state_reg == ST_ISSUE) begin
            issue_cnt_next = issue_cnt_reg + 1'b1;
            if (force_end) begin
                timeout_next = 1'b1;
            end
        end
    end

    assign timeout_err = timeout_reg;
`else
    // Without the watchdog the issue limit has no meaning
    logic unused_cfg;
    assign unused_cfg  = (MAX_INSTR == 0);
    assign force_end   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Sequencer state, program counter and latched thread mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            mask_reg  <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            mask_reg  <= mask_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next            = state_reg;
        pc_next               = pc_reg;
        mask_next             = mask_reg;
        busy                  = 1'b1;
        done                  = 1'b0;
        issue_valid           = 1'b0;
        seq_bus.thread_active = '0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    mask_next  = active_mask;
                    pc_next    = base_pc;
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                seq_bus.thread_active = mask_reg;
                // An empty mask is detected once latched: finish without issuing
                state_next = (mask_reg == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                seq_bus.thread_active = mask_reg;
                issue_valid           = 1'b1;
                if (fields.op == OP_END || force_end) begin
                    state_next = ST_DRAIN;
                end else begin
                    pc_next    = pc_reg + 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                seq_bus.thread_active = mask_reg;
                if ((seq_bus.thread_complete & mask_reg) == mask_reg) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Broadcast fields are only non-zero while an instruction is issuing
    always_comb begin
        seq_bus.type_instruction = 3'b000;
        seq_bus.regnum_1         = '0;
        seq_bus.regnum_2         = '0;
        seq_bus.dest_reg         = '0;
        seq_bus.shammt           = '0;
        if (issue_valid) begin
            seq_bus.type_instruction = force_end ? 3'(OP_END) : 3'(fields.op);
            seq_bus.regnum_1         = fields.regnum_1;
            seq_bus.regnum_2         = fields.regnum_2;
            seq_bus.dest_reg         = fields.dest_reg;
            seq_bus.shammt           = fields.shammt;
        end
    end

    assign seq_bus.imem_addr = pc_reg;
endmodule

// File: tb/tb_warp_sequencer.sv
// Randomized self-checking bench for warp_sequencer. The reference model walks
// the instruction memory from base_pc to build the expected issue list and
// derives the cycle-by-cycle timeline (fetch/issue every 2 cycles, drain until
// the last masked thread completes, one-cycle done).
module tb_warp_sequencer;
    localparam int NT    = 8;
    localparam int DEPTH = 64;
    localparam int PCW   = 6;
`ifdef WARP_SEQ_TIMEOUT_EN
    localparam int MAXI  = 4;
`else
    localparam int MAXI  = 255;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [PCW-1:0] base_pc = '0;
    logic [NT-1:0]  active_mask = '0;
    logic           busy;
    logic           done;
    logic           timeout_err;
    logic [31:0]    imem [DEPTH];
    int             errors = 0;
    int             checks = 0;

    warp_sequencer_if #(.NUM_THREADS(NT), .PCW(PCW)) bus ();

    warp_sequencer #(
        .NUM_THREADS (NT),
        .IMEM_DEPTH  (DEPTH),
        .MAX_INSTR   (MAXI)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_pc     (base_pc),
        .active_mask (active_mask),
        .seq_bus     (bus),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Instruction memory with one-cycle registered read
    always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [4:0] rd,
                                       input logic [5:0] sh);
        return {op, r1, r2, rd, sh, 8'h00};
    endfunction

    // Fill memory with random non-END words, then place END after len words
    task automatic load_random(input logic [PCW-1:0] base, input int len);
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (w[31:29] == 3'b111) w[31:29] = 3'b110;
            imem[i] = w;
        end
        w = $urandom;
        w[31:29] = 3'b111;
        imem[(int'(base) + len - 1) % DEPTH] = w;
    endtask

    task automatic check_idle_outputs(input string tag, input logic exp_tmo);
        check_eq({tag, " busy"}, 32'(busy), 32'd0);
        check_eq({tag, " done"}, 32'(done), 32'd0);
        check_eq({tag, " active"}, 32'(bus.thread_active), 32'd0);
        check_eq({tag, " fields"}, 32'({bus.type_instruction, bus.regnum_1, bus.regnum_2,
                                        bus.dest_reg, bus.shammt}), 32'd0);
        check_eq({tag, " tmo"}, 32'(timeout_err), 32'(exp_tmo));
    endtask

    // Run one program and compare every cycle against the model timeline
    task automatic run_prog(input string name, input logic [PCW-1:0] base, input logic [NT-1:0] mask,
                            input int comp[NT], input int poke_cyc);
        logic [31:0] issued[$];
        logic [31:0] w;
        logic [31:0] e_word;
        bit          fin;
        bit          tmo;
        int          addr;
        int          n;
        int          last_comp;
        int          done_cyc;
        string       tg;
        fin       = 0;
        tmo       = 0;
        addr      = int'(base);
        last_comp = 0;
        if (mask != '0) begin
            while (!fin) begin
                w = imem[addr];
                if (w[31:29] == 3'b111) begin
                    fin = 1;
                end
`ifdef WARP_SEQ_TIMEOUT_EN
                else if (issued.size() == MAXI - 1) begin
                    w[31:29] = 3'b111;
                    tmo = 1;
                    fin = 1;
                end
`endif
                issued.push_back(w);
                addr = (addr + 1) % DEPTH;
            end
        end
        n = issued.size();
        for (int t = 0; t < NT; t++) begin
            if (mask[t] && comp[t] > last_comp) last_comp = comp[t];
        end
        if (mask == '0) done_cyc = 2;
        else done_cyc = ((2 * n + 1) > last_comp ? (2 * n + 1) : last_comp) + 1;

        @(negedge clk);
        base_pc              = base;
        active_mask          = mask;
        bus.thread_complete  = '0;
        start                = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            #1;
            start = (c == poke_cyc) && (c <= done_cyc);
            if (start) begin
                base_pc     = PCW'($urandom);
                active_mask = NT'($urandom);
            end
            for (int t = 0; t < NT; t++) begin
                if (comp[t] <= c) bus.thread_complete[t] = 1'b1;
            end
            #1;
            tg = $sformatf("%s c%0d", name, c);
            e_word = '0;
            if ((c % 2 == 0) && (c / 2 <= n)) e_word = issued[c / 2 - 1];
            check_eq({tg, " fields"}, 32'({bus.type_instruction, bus.regnum_1, bus.regnum_2,
                                           bus.dest_reg, bus.shammt}), 32'(e_word[31:8]));
            check_eq({tg, " busy"}, 32'(busy), 32'(c <= done_cyc));
            check_eq({tg, " done"}, 32'(done), 32'(c == done_cyc));
            check_eq({tg, " active"}, 32'(bus.thread_active), (c < done_cyc) ? 32'(mask) : 32'd0);
            check_eq({tg, " tmo"}, 32'(timeout_err), 32'(tmo && (c > 2 * n)));
            if ((c % 2 == 1) && (c <= ((n > 0) ? 2 * n - 1 : 1))) begin
                check_eq({tg, " addr"}, 32'(bus.imem_addr), 32'((int'(base) + (c - 1) / 2) % DEPTH));
            end
            @(posedge clk);
        end
        start = 1'b0;
        $display("run %s base=%0d mask=%02h issues=%0d done_cycle=%0d timeout=%0d",
                 name, base, mask, n, done_cyc, tmo);
    endtask

    initial begin
        int          comp[NT];
        logic [NT-1:0] m;
        logic [PCW-1:0] b;
        int          len;

        bus.thread_complete = '0;
        for (int i = 0; i < DEPTH; i++) imem[i] = '0;

        // Reset state while rst_n is held low
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset", 1'b0);
        check_eq("reset addr", 32'(bus.imem_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_idle_outputs("post-reset idle", 1'b0);
        end

        // ADD then END, all eight threads complete at cycle 8
        imem[4] = mk(3'b011, 5'd1, 5'd2, 5'd3, 6'd0);
        imem[5] = mk(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        for (int t = 0; t < NT; t++) comp[t] = 8;
        run_prog("add_end", 6'd4, 8'hFF, comp, 0);

        // Empty mask: done two cycles after start, nothing issued
        for (int t = 0; t < NT; t++) comp[t] = 0;
        run_prog("mask_zero", 6'd4, 8'h00, comp, 0);

        // Thread 3 is late; unmasked threads 4-7 partly complete, partly never
        imem[30] = mk(3'b010, 5'd7, 5'd8, 5'd9, 6'd5);
        imem[31] = mk(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        comp = '{6, 6, 6, 16, 1, 1, 500, 500};
        run_prog("late_thread", 6'd30, 8'h0F, comp, 3);

        // PC wraps from 63 to 0
        imem[63] = mk(3'b001, 5'd31, 5'd30, 5'd29, 6'd63);
        imem[0]  = mk(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        for (int t = 0; t < NT; t++) comp[t] = 3;
        run_prog("wrap", 6'd63, 8'hA5, comp, 0);

        // Long program without an early END (times out when the watchdog is built)
        for (int i = 0; i < 6; i++) imem[20 + i] = mk(3'b110, 5'(i), 5'(i + 1), 5'(i + 2), 6'(i));
        imem[26] = mk(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        for (int t = 0; t < NT; t++) comp[t] = 2;
        run_prog("no_end", 6'd20, 8'h3C, comp, 0);
        run_prog("after_no_end", 6'd4, 8'h01, comp, 0);

        // Reset in the middle of DRAIN
        imem[10] = mk(3'b011, 5'd4, 5'd5, 5'd6, 6'd1);
        imem[11] = mk(3'b111, 5'd0, 5'd0, 5'd0, 6'd0);
        @(negedge clk);
        base_pc             = 6'd10;
        active_mask         = 8'hFF;
        bus.thread_complete = '0;
        start               = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("drain before reset busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset", 1'b0);
        check_eq("async reset addr", 32'(bus.imem_addr), 32'd0);
        bus.thread_complete = '1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_idle_outputs("idle after reset", 1'b0);
        end
        bus.thread_complete = '0;
        for (int t = 0; t < NT; t++) comp[t] = 7;
        run_prog("after_reset", 6'd10, 8'h81, comp, 0);

        // Randomized programs, masks, completion times and ignored starts
        for (int r = 0; r < 12; r++) begin
            m   = NT'($urandom);
            if ($urandom_range(0, 5) == 0) m = '0;
            b   = PCW'($urandom);
            len = $urandom_range(1, 8);
            load_random(b, len);
            for (int t = 0; t < NT; t++) comp[t] = $urandom_range(1, 2 * len + 8);
            run_prog($sformatf("rand%0d", r), b, m, comp, $urandom_range(0, 2 * len + 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
